// File: rtl/histogram_reader.sv
// Histogram sweep reader: reads every box of a histogramer in address order and
// streams {box address, box value} results through a first-word-fall-through buffer.

module histogram_reader #(
    parameter int    BOX_WIDTH  = 32,
    parameter int    BOX_CNT    = 32,
    parameter int    FIFO_DEPTH = 4,
    parameter string DEVICE     = "ULTRASCALE",
    localparam int   ADDR_W     = $clog2(BOX_CNT),
    localparam int   DATA_W     = ADDR_W + BOX_WIDTH
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 START,
    output logic                 BUSY,
    output logic                 DONE,
    input  logic                 HIST_RDY,
    output logic                 READ_REQ,
    output logic [ADDR_W-1:0]    READ_ADDR,
    input  logic                 READ_BOX_VLD,
    input  logic [BOX_WIDTH-1:0] READ_BOX,
    output logic [DATA_W-1:0]    TX_DATA,
    output logic                 TX_SRC_RDY,
    input  logic                 TX_DST_RDY,
    output logic                 OVERFLOW
);

    localparam int                CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam int                SUM_W     = CNT_W + 1;
    localparam int                PTR_W     = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BOX_CNT - 1);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);
    localparam bit                FPGA_RAM  = (DEVICE == "ULTRASCALE") ||
                                              (DEVICE == "ULTRASCALE_PLUS") ||
                                              (DEVICE == "7SERIES");

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SWEEP,
        ST_DRAIN
    } state_e;

    logic [1:0]        rst_sync_q;
    logic              rst_n_int;

    state_e            state_q;
    logic [ADDR_W-1:0] read_addr_q;
    logic [ADDR_W-1:0] resp_addr_q;
    logic [CNT_W-1:0]  outst_q;
    logic              overflow_q;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  fifo_cnt_q;

    logic              fifo_empty;
    logic              fifo_full;
    logic              fifo_wr;
    logic              tx_fire;
    logic              resp_vld;
    logic              read_issue;
    logic [SUM_W-1:0]  in_flight;

    // Reset asserts asynchronously but is released only after two clean edges.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n_int = rst_sync_q[1];

    assign fifo_empty = (fifo_cnt_q == '0);
    assign fifo_full  = (fifo_cnt_q == CNT_FULL);
    assign in_flight  = SUM_W'(outst_q) + SUM_W'(fifo_cnt_q);
    assign read_issue = (state_q == ST_SWEEP) && HIST_RDY &&
                        (in_flight < SUM_W'(FIFO_DEPTH));
    assign resp_vld   = READ_BOX_VLD && (state_q != ST_IDLE);
    assign tx_fire    = !fifo_empty && TX_DST_RDY;
    assign fifo_wr    = resp_vld && (!fifo_full || tx_fire);

    // DONE is decoded in the transfer cycle itself so that BUSY is still high
    // while it pulses and a START in that cycle is ignored.
    assign DONE       = (state_q == ST_DRAIN) && tx_fire &&
                        (TX_DATA[DATA_W-1:BOX_WIDTH] == LAST_ADDR);

    assign BUSY       = (state_q != ST_IDLE);
    assign READ_REQ   = read_issue;
    assign READ_ADDR  = read_addr_q;
    assign TX_SRC_RDY = !fifo_empty;
    assign TX_DATA    = mem_q[rd_ptr_q];
    assign OVERFLOW   = overflow_q;

    always_ff @(posedge CLK or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q     <= ST_IDLE;
            read_addr_q <= '0;
            resp_addr_q <= '0;
            outst_q     <= '0;
            overflow_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (START) begin
                        state_q     <= ST_SWEEP;
                        read_addr_q <= '0;
                        resp_addr_q <= '0;
                    end
                end
                ST_SWEEP: begin
                    if (read_issue) begin
                        read_addr_q <= read_addr_q + ADDR_W'(1);
                        if (read_addr_q == LAST_ADDR) begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (DONE) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            if (resp_vld) begin
                resp_addr_q <= resp_addr_q + ADDR_W'(1);
            end

            // A response with nothing outstanding is a protocol error; keep the
            // counter from wrapping so issue throttling stays sane.
            case ({read_issue, resp_vld && (outst_q != '0)})
                2'b10:   outst_q <= outst_q + CNT_W'(1);
                2'b01:   outst_q <= outst_q - CNT_W'(1);
                default: ;
            endcase

            if (resp_vld && fifo_full && !tx_fire) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge rst_n_int) begin
        if (!rst_n_int) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (fifo_wr) begin
                wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (tx_fire) begin
                rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            case ({fifo_wr, tx_fire})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + CNT_W'(1);
                2'b01:   fifo_cnt_q <= fifo_cnt_q - CNT_W'(1);
                default: ;
            endcase
        end
    end

    if (FPGA_RAM) begin : g_lutram
        // NOTE: storage is left unreset so it maps onto distributed RAM; the
        // pointers and count alone define which entries are valid.
        always_ff @(posedge CLK) begin
            if (fifo_wr) begin
                mem_q[wr_ptr_q] <= {resp_addr_q, READ_BOX};
            end
        end
    end else begin : g_flops
        always_ff @(posedge CLK or negedge rst_n_int) begin
            if (!rst_n_int) begin
                mem_q <= '{default: '0};
            end else if (fifo_wr) begin
                mem_q[wr_ptr_q] <= {resp_addr_q, READ_BOX};
            end
        end
    end

endmodule

// File: tb/tb_histogram_reader.sv
// Self-checking bench for histogram_reader: a histogramer responder plus a
// transaction-level model of the sweep (reads issued, results delivered/sent).

module tb_histogram_reader;

    localparam int BOX_WIDTH  = 16;
    localparam int BOX_CNT    = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int ADDR_W     = $clog2(BOX_CNT);
    localparam int DATA_W     = ADDR_W + BOX_WIDTH;

    logic                 CLK = 1'b0;
    logic                 RST_N;
    logic                 START;
    logic                 BUSY;
    logic                 DONE;
    logic                 HIST_RDY;
    logic                 READ_REQ;
    logic [ADDR_W-1:0]    READ_ADDR;
    logic                 READ_BOX_VLD;
    logic [BOX_WIDTH-1:0] READ_BOX;
    logic [DATA_W-1:0]    TX_DATA;
    logic                 TX_SRC_RDY;
    logic                 TX_DST_RDY;
    logic                 OVERFLOW;

    always #5 CLK = ~CLK;

    histogram_reader #(
        .BOX_WIDTH  (BOX_WIDTH),
        .BOX_CNT    (BOX_CNT),
        .FIFO_DEPTH (FIFO_DEPTH),
        .DEVICE     ("ULTRASCALE")
    ) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .START        (START),
        .BUSY         (BUSY),
        .DONE         (DONE),
        .HIST_RDY     (HIST_RDY),
        .READ_REQ     (READ_REQ),
        .READ_ADDR    (READ_ADDR),
        .READ_BOX_VLD (READ_BOX_VLD),
        .READ_BOX     (READ_BOX),
        .TX_DATA      (TX_DATA),
        .TX_SRC_RDY   (TX_SRC_RDY),
        .TX_DST_RDY   (TX_DST_RDY),
        .OVERFLOW     (OVERFLOW)
    );

    typedef struct {
        int due;
        int addr;
    } resp_t;

    resp_t                resp_q[$];
    logic [BOX_WIDTH-1:0] box_mem [BOX_CNT];

    int  n_checks = 0;
    int  n_fail   = 0;
    int  cyc      = 0;
    bit  busy_m, ovf_m, start_blocked, inject_vld, prev_stall;
    int  issued, delivered, transferred, last_due, lat_min, lat_max;
    int  dut_reads, dut_dones;
    logic [DATA_W-1:0] prev_tx;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: entered 1 time unit after a rising edge, leaves at the same
    // point of the next cycle. Model state advances as the edge would.
    task automatic run_cycle(input bit start, input bit hrdy, input bit drdy);
        bit                was_busy, exp_req, exp_src, fire, exp_done, real_vld;
        int                lat, due;
        logic [DATA_W-1:0] exp_tx;
        START      = start;
        HIST_RDY   = hrdy;
        TX_DST_RDY = drdy;
        real_vld   = (resp_q.size() > 0) && (resp_q[0].due == cyc);
        if (real_vld) begin
            READ_BOX_VLD = 1'b1;
            READ_BOX     = box_mem[resp_q[0].addr];
        end else begin
            READ_BOX_VLD = inject_vld;
            READ_BOX     = BOX_WIDTH'($urandom);
        end
        #1;
        was_busy = busy_m;
        exp_src  = delivered > transferred;
        exp_req  = busy_m && (issued < BOX_CNT) && hrdy && ((issued - transferred) < FIFO_DEPTH);
        fire     = exp_src && drdy;
        exp_done = fire && (transferred == BOX_CNT - 1);

        check("busy", BUSY, busy_m);
        check("read_req", READ_REQ, exp_req);
        if (exp_req) check("read_addr", READ_ADDR, issued);
        check("tx_src_rdy", TX_SRC_RDY, exp_src);
        if (fire) begin
            exp_tx = {ADDR_W'(transferred), box_mem[transferred]};
            check("tx_data", TX_DATA, exp_tx);
        end
        if (prev_stall) begin
            check("stall_src", TX_SRC_RDY, 1);
            check("stall_data", TX_DATA, prev_tx);
        end
        check("done", DONE, exp_done);
        check("overflow", OVERFLOW, ovf_m);
        if (READ_REQ) dut_reads++;
        if (DONE) dut_dones++;

        if (real_vld || (inject_vld && busy_m)) begin
            if ((delivered - transferred) == FIFO_DEPTH && !fire) ovf_m = 1'b1;
            else delivered++;
        end
        if (real_vld) void'(resp_q.pop_front());
        if (exp_req) begin
            lat = $urandom_range(lat_max, lat_min);
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            resp_q.push_back('{due, issued});
            issued++;
        end
        if (fire) transferred++;
        if (exp_done) busy_m = 1'b0;
        if (start && !was_busy && !start_blocked) begin
            busy_m      = 1'b1;
            issued      = 0;
            delivered   = 0;
            transferred = 0;
        end
        prev_stall = exp_src && !drdy;
        prev_tx    = TX_DATA;

        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, BUSY, 0);
        check({tag, "_done"}, DONE, 0);
        check({tag, "_read_req"}, READ_REQ, 0);
        check({tag, "_read_addr"}, READ_ADDR, 0);
        check({tag, "_tx_src_rdy"}, TX_SRC_RDY, 0);
        check({tag, "_overflow"}, OVERFLOW, 0);
    endtask

    // RST_N rises here; START at the first edge after the rise must be ignored.
    task automatic release_reset();
        resp_q.delete();
        busy_m      = 1'b0;
        ovf_m       = 1'b0;
        inject_vld  = 1'b0;
        prev_stall  = 1'b0;
        issued      = 0;
        delivered   = 0;
        transferred = 0;
        last_due    = cyc;
        RST_N       = 1'b1;
        start_blocked = 1'b1;
        run_cycle(1'b1, 1'b1, 1'b1);
        start_blocked = 1'b0;
        run_cycle(1'b0, 1'b1, 1'b1);
    endtask

    task automatic do_reset_async();
        #2;
        RST_N        = 1'b0;
        START        = 1'b0;
        READ_BOX_VLD = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        repeat (2) @(posedge CLK);
        #1;
        release_reset();
    endtask

    task automatic begin_sweep(input int lmin, input int lmax);
        lat_min   = lmin;
        lat_max   = lmax;
        dut_reads = 0;
        dut_dones = 0;
        for (int i = 0; i < BOX_CNT; i++) box_mem[i] = BOX_WIDTH'($urandom);
        run_cycle(1'b1, 1'b1, 1'b1);
    endtask

    task automatic run_until_idle(input string tag, input int budget, input int drdy_pct,
                                  input int hrdy_pct, input int start_pct);
        int n;
        n = 0;
        while (busy_m && n < budget) begin
            run_cycle($urandom_range(99, 0) < start_pct, $urandom_range(99, 0) < hrdy_pct,
                      $urandom_range(99, 0) < drdy_pct);
            n++;
        end
        if (n >= budget) check({tag, "_timeout"}, BUSY, 0);
        check({tag, "_reads"}, dut_reads, BOX_CNT);
        check({tag, "_dones"}, dut_dones, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int r0;
        int pause_reads;
        bit st;

        RST_N        = 1'b0;
        START        = 1'b0;
        HIST_RDY     = 1'b0;
        READ_BOX_VLD = 1'b0;
        READ_BOX     = '0;
        TX_DST_RDY   = 1'b0;
        lat_min      = 2;
        lat_max      = 2;
        repeat (2) @(posedge CLK);
        #1;
        check_reset_outputs("por");
        release_reset();

        // Basic sweep, latency 2, with START asserted in the DONE cycle.
        begin_sweep(2, 2);
        n = 0;
        while (busy_m && n < 100) begin
            st = (transferred == BOX_CNT - 1) && (delivered > transferred);
            run_cycle(st, 1'b1, 1'b1);
            n++;
        end
        if (n >= 100) check("basic_timeout", BUSY, 0);
        check("basic_reads", dut_reads, BOX_CNT);
        check("basic_dones", dut_dones, 1);

        // START the cycle right after DONE starts the next sweep.
        begin_sweep(2, 2);
        run_until_idle("back2back", 200, 100, 100, 0);

        // Consumer stalled: only FIFO_DEPTH reads may be issued.
        begin_sweep(2, 2);
        repeat (20) run_cycle(1'b0, 1'b1, 1'b0);
        check("stall_reads", dut_reads, FIFO_DEPTH);
        run_until_idle("stall", 200, 100, 100, 0);

        // Histogramer not ready in cycles 3-10 after START.
        begin_sweep(2, 2);
        pause_reads = 0;
        for (int k = 1; k <= 200 && busy_m; k++) begin
            r0 = dut_reads;
            run_cycle(1'b0, !(k >= 3 && k <= 10), 1'b1);
            if (k >= 3 && k <= 10) pause_reads += dut_reads - r0;
        end
        check("pause_reads", pause_reads, 0);
        if (busy_m) check("pause_timeout", BUSY, 0);
        check("pause_total_reads", dut_reads, BOX_CNT);
        check("pause_dones", dut_dones, 1);

        // Random backpressure, latency and stray START pulses.
        for (int s = 0; s < 6; s++) begin
            begin_sweep(1, 3);
            run_until_idle("random", 400, 50, 85, 10);
        end

        // Asynchronous reset mid-sweep, then a complete fresh sweep.
        begin_sweep(2, 2);
        repeat (4) run_cycle(1'b0, 1'b1, 1'b1);
        do_reset_async();
        begin_sweep(2, 2);
        run_until_idle("post_reset", 200, 100, 100, 0);

        // Extra response while the buffer is full and stalled.
        begin_sweep(1, 1);
        repeat (12) run_cycle(1'b0, 1'b1, 1'b0);
        check("pre_ovf_full", TX_SRC_RDY, 1);
        inject_vld = 1'b1;
        run_cycle(1'b0, 1'b1, 1'b0);
        inject_vld = 1'b0;
        repeat (10) run_cycle(1'b0, 1'b1, 1'b0);
        check("overflow_held", OVERFLOW, 1);
        do_reset_async();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/histogram_reader.md
HISTOGRAM_READER -- requirements
Module: histogram_reader

Interface
REQ-001 Parameter BOX_WIDTH, default 32: width of one histogram box value.
REQ-002 Parameter BOX_CNT, default 32: number of boxes swept; power of two, >= 2.
REQ-003 Parameter FIFO_DEPTH, default 4: result buffer depth and maximum outstanding reads; >= 2.
REQ-004 Parameter DEVICE, default "ULTRASCALE": target device string, passed to the FIFO.
REQ-005 Clocking: one clock and an asynchronous, active-low reset.
REQ-006 CLK  in  1  sole clock; all logic rising-edge.
REQ-007 RST_N  in  1  asynchronous active-low reset.
REQ-008 START  in  1  single-cycle sweep start request.
REQ-009 BUSY  out  1  high while a sweep is in progress.
REQ-010 DONE  out  1  one-cycle pulse when the last result of a sweep is accepted at TX.
REQ-011 HIST_RDY  in  1  histogramer reset-done/ready; a read is issued only while high.
REQ-012 READ_REQ  out  1  read request to the histogramer.
REQ-013 READ_ADDR  out  log2(BOX_CNT)  box address of the read.
REQ-014 READ_BOX_VLD  in  1  read response valid; no backpressure possible.
REQ-015 READ_BOX  in  BOX_WIDTH  read response value.
REQ-016 TX_DATA  out  log2(BOX_CNT)+BOX_WIDTH  result: {box address, box value}, address in MSBs.
REQ-017 TX_SRC_RDY  out  1  result valid.
REQ-018 TX_DST_RDY  in  1  consumer ready; transfer when TX_SRC_RDY and TX_DST_RDY are both high.
REQ-019 OVERFLOW  out  1  sticky error: response arrived with the FIFO full.

Function
REQ-020 FSM states: IDLE, SWEEP (issuing reads), DRAIN (all reads issued, awaiting responses and TX).
REQ-021 IDLE->SWEEP on START=1; START SHALL be ignored in SWEEP and DRAIN.
REQ-022 In SWEEP, READ_REQ=1 iff HIST_RDY=1 and outstanding + FIFO occupancy < FIFO_DEPTH; at most one read per cycle.
REQ-023 READ_ADDR SHALL start at 0 per sweep and increment by 1 per issued read.
REQ-024 SWEEP->DRAIN in the cycle the read for address BOX_CNT-1 is issued.
REQ-025 Outstanding counter (width log2(FIFO_DEPTH+1)): +1 per read, -1 per READ_BOX_VLD; both in one cycle leaves it unchanged.
REQ-026 Responses arrive in request order with arbitrary latency >= 1; every READ_BOX_VLD SHALL be written to the FIFO in the same cycle.
REQ-027 The response address SHALL come from a separate response counter, reset to 0 per sweep, +1 per response.
REQ-028 The FIFO is first-word-fall-through: TX_SRC_RDY = FIFO not empty; TX_DATA is the FIFO head; simultaneous write and read SHALL be allowed when full or empty.
REQ-029 TX_DATA and TX_SRC_RDY SHALL stay stable while TX_SRC_RDY=1 and TX_DST_RDY=0.
REQ-030 DRAIN->IDLE, with DONE=1 for one cycle, on the TX transfer of the result for address BOX_CNT-1.
REQ-031 BUSY = (state != IDLE); START in the DONE cycle is ignored; START in the following cycle begins a new sweep.
REQ-032 If READ_BOX_VLD=1 while the FIFO is full and not read in the same cycle: the response is dropped, OVERFLOW is set, and it stays set until reset.
REQ-033 HIST_RDY dropping mid-sweep SHALL only pause issue; sweep state is retained.

Reset
REQ-034 RST_N=0 SHALL immediately, with no clock edge, force: state IDLE; BUSY=0, DONE=0, READ_REQ=0, READ_ADDR=0, TX_SRC_RDY=0, OVERFLOW=0.
REQ-035 Reset SHALL empty the FIFO and clear all counters.
REQ-036 Reset deassertion SHALL be synchronised internally; the first START is honoured no earlier than the 2nd CLK edge after RST_N rises.
REQ-037 Reset mid-sweep aborts the sweep; responses to previously issued reads arriving after reset are ignored by the bench.

Verification (BOX_CNT=8, FIFO_DEPTH=4, BOX_WIDTH=16)
REQ-038 START, HIST_RDY=1, latency 2, TX_DST_RDY=1 -> 8 results {0,v0}..{7,v7} in order; DONE once; BUSY low the cycle after DONE.
REQ-039 TX_DST_RDY=0 throughout sweep -> exactly 4 reads issued (addresses 0-3), then READ_REQ=0; after TX_DST_RDY=1 the sweep completes with 8 correct results.
REQ-040 HIST_RDY=0 for cycles 3-10 after START -> no READ_REQ during them; the sweep then resumes at the next address with no gap or duplicate.
REQ-041 Random TX_DST_RDY (50%) and latency 1-3 -> results match the model; TX_DATA stable while stalled; OVERFLOW stays 0.
REQ-042 RST_N=0 asserted asynchronously mid-SWEEP -> all outputs at reset values before the next edge; a new START yields a full 0..7 sweep.
REQ-043 Forced extra READ_BOX_VLD with the FIFO full -> OVERFLOW=1 and held until reset.
